mix_seq_ctrl: RTL and testbench

Parametrised sequencer for the DryGASCON Mix phase. It walks an arbitrary-width input in DWIDTH-bit slices and alternates mix-step and permutation-step invocations on an internally held state, with PERM_ROUNDS permutation rounds between mixes. The engines (mixsx32, Gascon_Core_Round) sit outside the block and are driven over go/clr/done handshakes. The block adds start/busy/done handshaking, abort, a zero-padded final slice and multi-round permutation, so it can be used for both the 128-bit and 256-bit sponge variants.

---
 rtl/mix_seq_ctrl_if.sv | 31 +++
 rtl/mix_seq_ctrl.sv | 168 ++++++++++++++++
 tb/tb_mix_seq_ctrl.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mix_seq_ctrl_if.sv
// Engine-side bundle of the DryGASCON Mix sequencer: mix and permutation
// go/clr/done handshakes plus the shared state and slice buses.
interface mix_seq_ctrl_if #(
    parameter int CWIDTH      = 320,
    parameter int DWIDTH      = 10,
    parameter int PERM_ROUNDS = 1
);
    localparam int RW = $clog2(PERM_ROUNDS) + 1;

    logic              mix_clr;
    logic              mix_go;
    logic [CWIDTH-1:0] mix_c;
    logic [DWIDTH-1:0] mix_d;
    logic [CWIDTH-1:0] mix_cout;
    logic              mix_done;
    logic              perm_clr;
    logic              perm_go;
    logic [RW-1:0]     perm_round;
    logic [CWIDTH-1:0] perm_cout;
    logic              perm_done;

    modport master (
        output mix_clr, mix_go, mix_c, mix_d, perm_clr, perm_go, perm_round,
        input  mix_cout, mix_done, perm_cout, perm_done
    );

    modport slave (
        input  mix_clr, mix_go, mix_c, mix_d, perm_clr, perm_go, perm_round,
        output mix_cout, mix_done, perm_cout, perm_done
    );
endinterface

// File: rtl/mix_seq_ctrl.sv
// DryGASCON Mix-phase sequencer: absorbs in_value in DWIDTH-bit slices,
// alternating external mix steps with PERM_ROUNDS permutation rounds.
module mix_seq_ctrl #(
    parameter int CWIDTH      = 320,
    parameter int DWIDTH      = 10,
    parameter int IN_WIDTH    = 256,
    parameter int PERM_ROUNDS = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic [CWIDTH-1:0]   c_in,
    input  logic [IN_WIDTH-1:0] in_value,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [CWIDTH-1:0]   c_out,
    mix_seq_ctrl_if.master      eng
);
    localparam int MIXROUNDS = (IN_WIDTH + DWIDTH - 1) / DWIDTH;
    localparam int PADW      = MIXROUNDS * DWIDTH;
    localparam int JW        = $clog2(MIXROUNDS) + 1;
    localparam int RW        = $clog2(PERM_ROUNDS) + 1;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD     = 3'd1,
        S_MIX_CLR  = 3'd2,
        S_MIX      = 3'd3,
        S_PERM_CLR = 3'd4,
        S_PERM     = 3'd5,
        S_DONE     = 3'd6
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic [CWIDTH-1:0]   c_r;
    logic [IN_WIDTH-1:0] in_r;
    logic [JW-1:0]       j_r;
    logic [RW-1:0]       r_r;
    logic                busy_r;
    logic                done_r;
    logic                error_r;
    logic                mix_clr_r;
    logic                mix_go_r;
    logic                perm_clr_r;
    logic                perm_go_r;
    logic [PADW-1:0]     padded_s;
    int                  slice_base_s;
    logic                mix_last_s;
    logic                perm_last_s;

    assign mix_last_s   = (j_r == JW'(MIXROUNDS - 1));
    assign perm_last_s  = (r_r == RW'(PERM_ROUNDS - 1));
    // Zero extension provides the padding of the final slice.
    assign padded_s     = PADW'(in_r);
    assign slice_base_s = int'(j_r) * DWIDTH;

    // Next-state selection; abort wins over any engine done in busy states.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start && !abort) state_nxt_s = S_LOAD;
                else                 state_nxt_s = S_IDLE;
            end
            S_LOAD: begin
                if (abort) state_nxt_s = S_IDLE;
                else       state_nxt_s = S_MIX_CLR;
            end
            S_MIX_CLR: begin
                if (abort) state_nxt_s = S_IDLE;
                else       state_nxt_s = S_MIX;
            end
            S_MIX: begin
                if (abort)                        state_nxt_s = S_IDLE;
                else if (eng.mix_done && mix_last_s) state_nxt_s = S_DONE;
                else if (eng.mix_done)            state_nxt_s = S_PERM_CLR;
                else                              state_nxt_s = S_MIX;
            end
            S_PERM_CLR: begin
                if (abort) state_nxt_s = S_IDLE;
                else       state_nxt_s = S_PERM;
            end
            S_PERM: begin
                if (abort)                            state_nxt_s = S_IDLE;
                else if (eng.perm_done && perm_last_s) state_nxt_s = S_MIX_CLR;
                else if (eng.perm_done)               state_nxt_s = S_PERM_CLR;
                else                                  state_nxt_s = S_PERM;
            end
            S_DONE: begin
                if (start) state_nxt_s = S_LOAD;
                else       state_nxt_s = S_DONE;
            end
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // State, datapath and status/strobe registers decoded from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= S_IDLE;
            c_r        <= '0;
            in_r       <= '0;
            j_r        <= '0;
            r_r        <= '0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            error_r    <= 1'b0;
            mix_clr_r  <= 1'b0;
            mix_go_r   <= 1'b0;
            perm_clr_r <= 1'b0;
            perm_go_r  <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            busy_r     <= (state_nxt_s != S_IDLE) && (state_nxt_s != S_DONE);
            done_r     <= (state_nxt_s == S_DONE);
            mix_clr_r  <= (state_nxt_s == S_MIX_CLR);
            mix_go_r   <= (state_nxt_s == S_MIX);
            perm_clr_r <= (state_nxt_s == S_PERM_CLR);
            perm_go_r  <= (state_nxt_s == S_PERM);

            if (busy_r && abort)              error_r <= 1'b1;
            else if (state_nxt_s == S_LOAD)   error_r <= 1'b0;
            else                              error_r <= error_r;

            case (state_r)
                S_LOAD: begin
                    if (!abort) begin
                        c_r  <= c_in;
                        in_r <= in_value;
                        j_r  <= '0;
                        r_r  <= '0;
                    end
                end
                S_MIX: begin
                    if (!abort && eng.mix_done) begin
                        c_r <= eng.mix_cout;
                        if (!mix_last_s) r_r <= '0;
                    end
                end
                S_PERM: begin
                    if (!abort && eng.perm_done) begin
                        c_r <= eng.perm_cout;
                        if (perm_last_s) j_r <= j_r + JW'(1'b1);
                        else             r_r <= r_r + RW'(1'b1);
                    end
                end
                default: begin
                    c_r <= c_r;
                end
            endcase
        end
    end

    assign busy           = busy_r;
    assign done           = done_r;
    assign error          = error_r;
    assign c_out          = c_r;
    assign eng.mix_c      = c_r;
    assign eng.mix_d      = padded_s[slice_base_s +: DWIDTH];
    assign eng.mix_clr    = mix_clr_r;
    assign eng.mix_go     = mix_go_r;
    assign eng.perm_clr   = perm_clr_r;
    assign eng.perm_go    = perm_go_r;
    assign eng.perm_round = r_r;
endmodule

// File: tb/tb_mix_seq_ctrl.sv
// Self-checking bench for mix_seq_ctrl: table vectors, random operations
// against a slice/round reference model, and abort/reset/back-to-back cases.
module tb_mix_seq_ctrl;
    localparam int CW = 128;
    localparam int DW = 4;
    localparam int IW = 10;
    localparam int PR = 2;
    localparam int MR = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          abort;
    logic [CW-1:0] c_in;
    logic [IW-1:0] in_value;
    logic          busy;
    logic          done;
    logic          error;
    logic [CW-1:0] c_out;

    int checks   = 0;
    int failures = 0;
    int nm, np, fsel, mcnt, pcnt;
    logic [DW-1:0] obs_d[$];
    int            obs_r[$];

    mix_seq_ctrl_if #(.CWIDTH(CW), .DWIDTH(DW), .PERM_ROUNDS(PR)) eng();

    mix_seq_ctrl #(.CWIDTH(CW), .DWIDTH(DW), .IN_WIDTH(IW), .PERM_ROUNDS(PR)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .c_in(c_in), .in_value(in_value), .busy(busy), .done(done),
        .error(error), .c_out(c_out), .eng(eng)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CW-1:0] ci;
        logic [IW-1:0] iv;
        int            nm;
        int            np;
        logic [CW-1:0] exp_c;
        int            exp_busy;
    } vec_t;
    vec_t vecs[4];

    function automatic logic [CW-1:0] mix_f(input logic [CW-1:0] c, input logic [DW-1:0] d, input int fs);
        if (fs == 0) return c + 128'd1;
        return {c[CW-2:0], c[CW-1]} ^ CW'(d) ^ 128'h9E37_79B9;
    endfunction

    function automatic logic [CW-1:0] perm_f(input logic [CW-1:0] c, input int r, input int fs);
        if (fs == 0) return c ^ 128'd1;
        return c ^ (c >> 7) ^ (CW'(r) << 64) ^ 128'h5;
    endfunction

    function automatic logic [CW-1:0] model_c(input logic [CW-1:0] ci, input logic [IW-1:0] iv, input int fs);
        logic [CW-1:0] c;
        c = ci;
        for (int j = 0; j < MR; j++) begin
            c = mix_f(c, DW'(iv >> (j * DW)), fs);
            if (j < MR - 1)
                for (int r = 0; r < PR; r++) c = perm_f(c, r, fs);
        end
        return c;
    endfunction

    function automatic int model_busy(input int m, input int p);
        return 1 + MR * (1 + m) + (MR - 1) * PR * (1 + p);
    endfunction

    task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: sample after the edge, then answer as the external engines.
    task automatic tick();
        @(posedge clk);
        #1;
        mcnt = eng.mix_go  ? mcnt + 1 : 0;
        pcnt = eng.perm_go ? pcnt + 1 : 0;
        eng.mix_done  = eng.mix_go  && (mcnt == nm);
        eng.perm_done = eng.perm_go && (pcnt == np);
        eng.mix_cout  = mix_f(eng.mix_c, eng.mix_d, fsel);
        eng.perm_cout = perm_f(eng.mix_c, int'(eng.perm_round), fsel);
        if (eng.mix_done)  obs_d.push_back(eng.mix_d);
        if (eng.perm_done) obs_r.push_back(int'(eng.perm_round));
    endtask

    task automatic run_op(input logic [CW-1:0] ci, input logic [IW-1:0] iv, input int m, input int p,
                          input int fs, output int bcnt, output bit fin);
        nm = m; np = p; fsel = fs;
        obs_d.delete(); obs_r.delete();
        c_in = ci; in_value = iv; start = 1'b1;
        tick();
        start = 1'b0;
        bcnt = 0; fin = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (done) begin fin = 1'b1; break; end
            if (busy) bcnt++;
            tick();
        end
    endtask

    task automatic chk_seq(input string tag, input logic [IW-1:0] iv);
        chk({tag, "_nslices"}, CW'(obs_d.size()), CW'(MR));
        for (int k = 0; k < MR && k < obs_d.size(); k++)
            chk({tag, "_slice"}, CW'(obs_d[k]), CW'(DW'(iv >> (k * DW))));
        chk({tag, "_nrounds"}, CW'(obs_r.size()), CW'((MR - 1) * PR));
        for (int k = 0; k < obs_r.size(); k++)
            chk({tag, "_round"}, CW'(obs_r[k]), CW'(k % PR));
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_flags"}, CW'({busy, done, error, eng.mix_clr, eng.mix_go, eng.perm_clr, eng.perm_go}), 128'd0);
        chk({tag, "_cout"}, c_out, 128'd0);
        chk({tag, "_mixd"}, CW'(eng.mix_d), 128'd0);
        chk({tag, "_round"}, CW'(eng.perm_round), 128'd0);
    endtask

    initial begin
        int  bcnt, viol;
        bit  fin;
        logic [CW-1:0] ci;
        logic [IW-1:0] iv;

        vecs[0] = '{ci: 128'd0,    iv: 10'h2D5, nm: 1, np: 1, exp_c: 128'd3,    exp_busy: 15};
        vecs[1] = '{ci: 128'd0,    iv: 10'h2D5, nm: 4, np: 3, exp_c: 128'd3,    exp_busy: 32};
        vecs[2] = '{ci: 128'h10,   iv: 10'h0A7, nm: 2, np: 1, exp_c: 128'h13,   exp_busy: 18};
        vecs[3] = '{ci: {CW{1'b1}}, iv: 10'h3FF, nm: 2, np: 2, exp_c: 128'd2,   exp_busy: 22};

        reset = 1'b1; start = 1'b0; abort = 1'b0; c_in = '0; in_value = '0;
        nm = 1; np = 1; fsel = 0; mcnt = 0; pcnt = 0;
        eng.mix_done = 1'b0; eng.perm_done = 1'b0; eng.mix_cout = '0; eng.perm_cout = '0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk_idle_zero("reset");
        viol = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (busy || done || eng.mix_clr || eng.perm_clr) viol++;
        end
        chk("idle_stays", CW'(viol), 128'd0);

        foreach (vecs[i]) begin
            run_op(vecs[i].ci, vecs[i].iv, vecs[i].nm, vecs[i].np, 0, bcnt, fin);
            chk("vec_finished", CW'(fin), 128'd1);
            chk("vec_busy_cycles", CW'(bcnt), CW'(vecs[i].exp_busy));
            chk("vec_cout", c_out, vecs[i].exp_c);
            chk("vec_busy_low_at_done", CW'(busy), 128'd0);
            chk_seq("vec", vecs[i].iv);
        end

        for (int t = 0; t < 16; t++) begin
            int m, p;
            ci = {$urandom, $urandom, $urandom, $urandom};
            iv = IW'($urandom);
            m  = $urandom_range(1, 4);
            p  = $urandom_range(1, 4);
            run_op(ci, iv, m, p, 1, bcnt, fin);
            chk("rnd_finished", CW'(fin), 128'd1);
            chk("rnd_busy_cycles", CW'(bcnt), CW'(model_busy(m, p)));
            chk("rnd_cout", c_out, model_c(ci, iv, 1));
            chk_seq("rnd", iv);
        end

        // Abort in the 2nd PERM cycle while perm_done is high.
        nm = 1; np = 2; fsel = 0;
        c_in = 128'h40; in_value = 10'h2D5; start = 1'b1;
        tick();
        start = 1'b0;
        fin = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (eng.perm_go && pcnt == 2) begin fin = 1'b1; break; end
            tick();
        end
        chk("abort_reached_perm2", CW'(fin), 128'd1);
        chk("abort_perm_done_high", CW'(eng.perm_done), 128'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", CW'(busy), 128'd0);
        chk("abort_error", CW'(error), 128'd1);
        chk("abort_done", CW'(done), 128'd0);
        chk("abort_strobes", CW'({eng.mix_clr, eng.mix_go, eng.perm_clr, eng.perm_go}), 128'd0);
        chk("abort_c_held", c_out, 128'h41);
        tick();
        chk("abort_idle_busy", CW'(busy), 128'd0);

        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("startabort_busy", CW'(busy), 128'd0);
        chk("startabort_error", CW'(error), 128'd1);
        tick();
        chk("startabort_stay_idle", CW'(busy), 128'd0);

        run_op(128'h40, 10'h2D5, 1, 1, 0, bcnt, fin);
        chk("post_abort_finished", CW'(fin), 128'd1);
        chk("post_abort_error", CW'(error), 128'd0);
        chk("post_abort_cout", c_out, 128'h43);

        // start held high throughout, then a start in the DONE cycle.
        nm = 1; np = 1; fsel = 0;
        c_in = 128'd0; in_value = 10'h2D5; start = 1'b1;
        tick();
        bcnt = 0; fin = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (done) begin fin = 1'b1; break; end
            if (busy) bcnt++;
            tick();
        end
        chk("b2b_finished", CW'(fin), 128'd1);
        chk("b2b_busy_cycles", CW'(bcnt), 128'd15);
        chk("b2b_cout", c_out, 128'd3);
        tick();
        start = 1'b0;
        chk("b2b_restart_busy", CW'(busy), 128'd1);
        chk("b2b_restart_done", CW'(done), 128'd0);
        fin = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (done) begin fin = 1'b1; break; end
            tick();
        end
        chk("b2b_second_finished", CW'(fin), 128'd1);
        chk("b2b_second_cout", c_out, 128'd3);

        // Reset while a mix is in progress.
        nm = 3; np = 1;
        c_in = 128'h77; in_value = 10'h3FF; start = 1'b1;
        tick();
        start = 1'b0;
        fin = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (eng.mix_go) begin fin = 1'b1; break; end
            tick();
        end
        chk("rstmix_reached_mix", CW'(fin), 128'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_idle_zero("rstmix");
        tick();
        chk("rstmix_stay_idle", CW'(busy), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
